// File: rtl/cordic_sincos_pipe.sv
// ============================================================================
//  Module   : cordic_sincos_pipe
//  Purpose  : Fully pipelined fixed-point CORDIC rotator producing cos/sin of
//             a signed Q3 radian angle every enabled clock.
//  Options  : CORDIC_QUAD_EXT_EN extends the input range to [-pi, pi).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_sincos_pipe #(
  parameter int WIDTH  = 22,
  parameter int STAGES = 16
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] angle,
  output logic             out_valid,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out
);

  localparam int DW = WIDTH + 2;
  localparam int SH = 32 - WIDTH;

  // Round-to-nearest right shift of a non-negative constant.
  function automatic logic [63:0] rnd_shr(input logic [63:0] v, input int s);
    rnd_shr = ((v << 1) + (64'd1 << s)) >> (s + 1);
  endfunction

  function automatic logic [31:0] atan_q29(input int idx);
    case (idx)
      0:       atan_q29 = 32'd421657428;
      1:       atan_q29 = 32'd248918915;
      2:       atan_q29 = 32'd131521918;
      3:       atan_q29 = 32'd66762579;
      4:       atan_q29 = 32'd33510843;
      5:       atan_q29 = 32'd16771758;
      6:       atan_q29 = 32'd8387925;
      7:       atan_q29 = 32'd4194219;
      8:       atan_q29 = 32'd2097141;
      9:       atan_q29 = 32'd1048575;
      10:      atan_q29 = 32'd524288;
      default: atan_q29 = (idx < 30) ? (32'd1 << (29 - idx)) : 32'd0;
    endcase
  endfunction

  function automatic logic signed [DW-1:0] atan_g(input int idx);
    atan_g = DW'(rnd_shr({32'd0, atan_q29(idx)}, SH) << 2);
  endfunction

  localparam logic [63:0]          K_Q32      = 64'd2608131496;
  localparam logic signed [DW-1:0] X_INIT     = DW'(rnd_shr(K_Q32, SH + 2) << 2);
  localparam logic signed [DW:0]   SAT_HI     = (DW+1)'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic signed [DW:0]   ROUND_HALF = (DW+1)'(2);

  function automatic logic [WIDTH-1:0] round_sat(input logic signed [DW:0] v);
    logic signed [DW:0] r;
    r = v + ROUND_HALF;
    r = r >>> 2;
    if (r > SAT_HI)
      round_sat = SAT_HI[WIDTH-1:0];
    else if (r < -SAT_HI)
      round_sat = (-SAT_HI) & {(DW+1){1'b1}};
    else
      round_sat = r[WIDTH-1:0];
  endfunction

  logic signed [DW-1:0] x_q [0:STAGES];
  logic signed [DW-1:0] x_d [0:STAGES];
  logic signed [DW-1:0] y_q [0:STAGES];
  logic signed [DW-1:0] y_d [0:STAGES];
  logic signed [DW-1:0] z_q [0:STAGES-1];
  logic signed [DW-1:0] z_d [0:STAGES-1];
  logic [STAGES:0]      v_q;
  logic [STAGES:0]      v_d;
  logic signed [WIDTH-1:0] ang_f;

  logic                 out_valid_q;
  logic [WIDTH-1:0]     cos_q, cos_d;
  logic [WIDTH-1:0]     sin_q, sin_d;
  logic signed [DW:0]   xo_w, yo_w;

`ifdef CORDIC_QUAD_EXT_EN
  localparam logic signed [WIDTH-1:0] PI_Q      = WIDTH'(rnd_shr(64'd1686629713, SH));
  localparam logic signed [WIDTH-1:0] HALF_PI_Q = WIDTH'(rnd_shr(64'd843314857, SH));

  logic            neg_w;
  logic [STAGES:0] neg_q;

  // Fold outer half-plane angles by pi; the flag negates the result later.
  always_comb begin
    ang_f = angle;
    neg_w = 1'b0;
    if ($signed(angle) > HALF_PI_Q) begin
      ang_f = $signed(angle) - PI_Q;
      neg_w = 1'b1;
    end else if ($signed(angle) < -HALF_PI_Q) begin
      ang_f = $signed(angle) + PI_Q;
      neg_w = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)
      neg_q <= '0;
    else if (clk_en)
      neg_q <= {neg_q[STAGES-1:0], neg_w};
  end
`else
  assign ang_f = angle;
`endif

  always_comb begin
    x_d[0] = X_INIT;
    y_d[0] = '0;
    z_d[0] = {ang_f, 2'b00};
    v_d    = {v_q[STAGES-1:0], in_valid};
    for (int k = 1; k <= STAGES; k++) begin
      if (z_q[k-1][DW-1]) begin
        x_d[k] = x_q[k-1] + (y_q[k-1] >>> (k - 1));
        y_d[k] = y_q[k-1] - (x_q[k-1] >>> (k - 1));
      end else begin
        x_d[k] = x_q[k-1] - (y_q[k-1] >>> (k - 1));
        y_d[k] = y_q[k-1] + (x_q[k-1] >>> (k - 1));
      end
    end
    // The last rotation stage needs only the sign of z, so no z register follows it.
    for (int k = 1; k < STAGES; k++) begin
      if (z_q[k-1][DW-1])
        z_d[k] = z_q[k-1] + atan_g(k - 1);
      else
        z_d[k] = z_q[k-1] - atan_g(k - 1);
    end
  end

  always_comb begin
    xo_w = {x_q[STAGES][DW-1], x_q[STAGES]};
    yo_w = {y_q[STAGES][DW-1], y_q[STAGES]};
`ifdef CORDIC_QUAD_EXT_EN
    if (neg_q[STAGES]) begin
      xo_w = -xo_w;
      yo_w = -yo_w;
    end
`endif
    cos_d = round_sat(xo_w);
    sin_d = round_sat(yo_w);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k <= STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++)
        z_q[k] <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
    end else if (clk_en) begin
      for (int k = 0; k <= STAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
      for (int k = 0; k < STAGES; k++)
        z_q[k] <= z_d[k];
      v_q         <= v_d;
      out_valid_q <= v_q[STAGES];
      cos_q       <= cos_d;
      sin_q       <= sin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_sincos_pipe.sv
// ============================================================================
//  Module   : tb_cordic_sincos_pipe
//  Purpose  : Scoreboard bench for cordic_sincos_pipe against a real-valued
//             sine/cosine model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_sincos_pipe;

  localparam int W   = 22;
  localparam int S   = 16;
  localparam int LAT = S + 2;
  // Accuracy budget plus the residual angle left after the final micro-rotation.
  localparam int TOL = S / 2 + 2 + (1 << (W - 1 - S));
  localparam int HP  = 823550;
  localparam int PI  = 1647099;

  logic         clock;
  logic         aclr;
  logic         clk_en;
  logic         in_valid;
  logic [W-1:0] angle;
  logic         out_valid;
  logic [W-1:0] cos_out;
  logic [W-1:0] sin_out;

  cordic_sincos_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clock    (clock),
    .aclr     (aclr),
    .clk_en   (clk_en),
    .in_valid (in_valid),
    .angle    (angle),
    .out_valid(out_valid),
    .cos_out  (cos_out),
    .sin_out  (sin_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int stamp;
    int ang;
    int ec;
    int es;
  } exp_t;

  exp_t sb[$];
  int   passes   = 0;
  int   total    = 0;
  int   edge_cnt = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  int   en_mode  = 0;
  bit   en_tog   = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic int ref_val(input int ang, input bit want_sin);
    real a, v;
    int  r;
    a = real'(ang) / real'(1 << (W - 3));
    v = want_sin ? $sin(a) : $cos(a);
    v = v * real'(1 << (W - 2));
    r = int'($floor(v + 0.5));
    if (r >  (1 << (W - 1)) - 1) r =  (1 << (W - 1)) - 1;
    if (r < -((1 << (W - 1)) - 1)) r = -((1 << (W - 1)) - 1);
    return r;
  endfunction

  function automatic bit next_en();
    case (en_mode)
      0:       return 1'b1;
      1: begin en_tog = ~en_tog; return en_tog; end
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  function automatic int rand_angle();
`ifdef CORDIC_QUAD_EXT_EN
    return int'($urandom_range(0, 2 * PI - 1)) - PI;
`else
    return int'($urandom_range(0, 2 * HP)) - HP;
`endif
  endfunction

  // Holds the sample on the inputs until an enabled edge captures it.
  task automatic send(input bit iv, input int ang);
    bit   cap;
    exp_t e;
    cap = 1'b0;
    while (!cap) begin
      @(negedge clock);
      clk_en   = next_en();
      in_valid = iv;
      angle    = ang[W-1:0];
      if (clk_en) begin
        cap = 1'b1;
        if (iv) begin
          e.stamp = edge_cnt + LAT;
          e.ang   = ang;
          e.ec    = ref_val(ang, 1'b0);
          e.es    = ref_val(ang, 1'b1);
          sb.push_back(e);
          n_in++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 0);
  endtask

  bit   mon_en;
  bit   exp_v;
  bit   pv;
  int   pc, ps, cs, ss, d;
  exp_t me;

  always @(posedge clock) begin
    mon_en = clk_en && !aclr;
    if (mon_en) edge_cnt++;
    #1;
    cs = int'($signed(cos_out));
    ss = int'($signed(sin_out));
    if (mon_en) begin
      exp_v = (sb.size() > 0) && (sb[0].stamp == edge_cnt);
      check(out_valid == exp_v, "out_valid", int'(out_valid), int'(exp_v));
      if (out_valid) n_out++;
      if (exp_v) begin
        me = sb.pop_front();
        d = cs - me.ec; if (d < 0) d = -d;
        check(d <= TOL, "cos_out", cs, me.ec);
        d = ss - me.es; if (d < 0) d = -d;
        check(d <= TOL, "sin_out", ss, me.es);
      end
    end else if (!aclr) begin
      check(out_valid == pv, "hold_valid", int'(out_valid), int'(pv));
      check(cs == pc && ss == ps, "hold_data", cs, pc);
    end
    pv = out_valid;
    pc = cs;
    ps = ss;
  end

  initial begin
    aclr     = 1'b1;
    clk_en   = 1'b0;
    in_valid = 1'b0;
    angle    = '0;
    repeat (3) @(negedge clock);
    check(out_valid == 1'b0, "reset_valid", int'(out_valid), 0);
    check(cos_out == '0, "reset_cos", int'(cos_out), 0);
    check(sin_out == '0, "reset_sin", int'(sin_out), 0);
    aclr = 1'b0;

    en_mode = 0;
    send(1'b1, 0);
    idle(LAT + 2);

    send(1'b1, 524288);
    send(1'b1, -524288);
    send(1'b1, 262144);
    idle(LAT + 2);

    en_mode = 1;
    send(1'b1, 524288);
    send(1'b1, -524288);
    send(1'b1, 262144);
    idle(LAT + 4);

    en_mode = 0;
    send(1'b1, HP);
    send(1'b1, -HP);
`ifdef CORDIC_QUAD_EXT_EN
    send(1'b1, PI);
    send(1'b1, -PI);
    send(1'b1, 1310720);
    send(1'b1, -1310720);
`endif
    idle(LAT + 2);

    for (int i = 0; i < 25; i++) send(1'b1, rand_angle());
    @(negedge clock);
    aclr     = 1'b1;
    in_valid = 1'b0;
    #1;
    check(out_valid == 1'b0, "aclr_valid", int'(out_valid), 0);
    check(cos_out == '0, "aclr_cos", int'(cos_out), 0);
    check(sin_out == '0, "aclr_sin", int'(sin_out), 0);
    n_in = n_in - sb.size();
    sb.delete();
    @(negedge clock);
    aclr = 1'b0;
    idle(LAT + 10);
    send(1'b1, 262144);
    idle(LAT + 2);

    en_mode = 2;
    for (int i = 0; i < 1024; i++) send($urandom_range(0, 4) != 0, rand_angle());
    idle(LAT + 4);

    en_mode = 0;
    for (int i = 0; i < 200 && sb.size() > 0; i++) idle(1);
    check(sb.size() == 0, "drain", sb.size(), 0);
    check(n_out == n_in, "valid_count", n_out, n_in);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
